// File: rtl/chi_home_node.sv
// chi_home_node: responder side of the simplified CHI request/response link.
// Accepts one Read/Write request at a time into a local word-addressed memory
// window. Each request produces an ACK pulse followed by a DATA or ERR pulse.
// Optional feature macro: CHI_HN_STATS_EN adds saturating completion counters
// (rd_count, wr_count, err_count).
module chi_home_node #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       MEM_DEPTH    = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h1000),
  parameter int unsigned       RESP_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        command,
  input  logic [DATA_W-1:0] write_data,
  input  logic              request_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              response_valid,
  output logic [1:0]        resp_opcode
`ifdef CHI_HN_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       err_count
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXT_W = ADDR_W + 1;

  localparam logic [3:0] CMD_READ  = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ACK  = 2'b01;
  localparam logic [1:0] OP_DATA = 2'b10;
  localparam logic [1:0] OP_ERR  = 2'b11;

  // Window bounds carried one bit wider so BASE_ADDR + span never wraps.
  localparam logic [EXT_W-1:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [EXT_W-1:0] SPAN_EXT  = EXT_W'(4 * MEM_DEPTH);
  localparam logic [EXT_W-1:0] LIMIT_EXT = BASE_EXT + SPAN_EXT;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_BUSY    = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                legal_q, legal_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          resp_op_q, resp_op_d;

  logic [DATA_W-1:0]   mem_q [0:MEM_DEPTH-1];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdata;

`ifdef CHI_HN_STATS_EN
  logic [15:0]         rd_count_q, rd_count_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic [15:0]         err_count_q, err_count_d;
`endif

  // Legality and word index derived from the latched request.
  logic [EXT_W-1:0]    addr_ext;
  logic [EXT_W-1:0]    offset_ext;
  logic [IDX_W-1:0]    idx_c;
  logic                cmd_rd_c;
  logic                cmd_wr_c;
  logic                legal_c;
  logic                unused_offset_bits;

  assign addr_ext           = {1'b0, addr_q};
  assign offset_ext         = addr_ext - BASE_EXT;
  assign idx_c              = offset_ext[IDX_W+1:2];
  assign cmd_rd_c           = (cmd_q == CMD_READ);
  assign cmd_wr_c           = (cmd_q == CMD_WRITE);
  assign legal_c            = (cmd_rd_c | cmd_wr_c)
                            & (addr_q[1:0] == 2'b00)
                            & (addr_ext >= BASE_EXT)
                            & (addr_ext < LIMIT_EXT);
  assign unused_offset_bits = ^{offset_ext[EXT_W-1:IDX_W+2], offset_ext[1:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (request_valid) state_d = ST_ACK;
      end
      ST_ACK: begin
        cnt_d   = CNT_W'(RESP_LATENCY);
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q != '0) cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        if (cnt_q <= CNT_W'(1)) state_d = ST_DATA;
      end
      ST_DATA: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!request_valid) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath logic; responses are computed for the state being entered.
  always_comb begin
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    legal_d      = legal_q;
    resp_valid_d = 1'b0;
    resp_op_d    = OP_NONE;
    read_data_d  = '0;
    mem_we       = 1'b0;
    mem_widx     = idx_c;
    mem_wdata    = wdata_q;
`ifdef CHI_HN_STATS_EN
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    err_count_d  = err_count_q;
`endif

    if ((state_q == ST_IDLE) && (state_d == ST_ACK)) begin
      addr_d  = addr;
      cmd_d   = command;
      wdata_d = write_data;
    end

    if (state_q == ST_ACK) begin
      legal_d = legal_c;
      mem_we  = legal_c & cmd_wr_c;
    end

    unique case (state_d)
      ST_ACK: begin
        resp_valid_d = 1'b1;
        resp_op_d    = OP_ACK;
      end
      ST_DATA: begin
        resp_valid_d = 1'b1;
        resp_op_d    = legal_q ? OP_DATA : OP_ERR;
        if (legal_q && cmd_rd_c) read_data_d = mem_q[idx_c];
`ifdef CHI_HN_STATS_EN
        if (!legal_q) begin
          if (err_count_q != 16'hFFFF) err_count_d = 16'(err_count_q + 16'd1);
        end else if (cmd_rd_c) begin
          if (rd_count_q != 16'hFFFF) rd_count_d = 16'(rd_count_q + 16'd1);
        end else begin
          if (wr_count_q != 16'hFFFF) wr_count_d = 16'(wr_count_q + 16'd1);
        end
`endif
      end
      default: begin
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Request latch and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      cmd_q        <= '0;
      wdata_q      <= '0;
      legal_q      <= 1'b0;
      read_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= OP_NONE;
    end else begin
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      legal_q      <= legal_d;
      read_data_q  <= read_data_d;
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
    end
  end

  // Memory window; cleared on reset so an aborted write leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

`ifdef CHI_HN_STATS_EN
  // Saturating completion counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

  assign read_data      = read_data_q;
  assign response_valid = resp_valid_q;
  assign resp_opcode    = resp_op_q;

endmodule
